// File: rtl/shift_exec_pipe.sv
// Two-stage pipelined shift/rotate unit (ROL/ROR/SLL/SRL/SRA) with valid/ready on both sides.
// Optional carry output enabled by defining SHIFT_CARRY_EN.
module shift_exec_pipe #(
    parameter int DW = 64,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [DW-1:0] D_in,
    input  logic [SW-1:0] samt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] D_out,
    output logic          zero,
`ifdef SHIFT_CARRY_EN
    output logic          carry,
`endif
    output logic          err
);

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_ROR = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    logic          s1_valid;
    logic [2:0]    s1_op;
    logic [DW-1:0] s1_data;
    logic [SW-1:0] s1_samt;
    logic          s2_valid;

    logic s2_can_load;
    logic s1_advance;
    logic in_xfer;

    assign s2_can_load = !s2_valid || out_ready;
    assign s1_advance  = s1_valid && s2_can_load;
    assign in_ready    = !reset && (!s1_valid || s2_can_load);
    assign in_xfer     = in_valid && in_ready;
    // The registered valid can still be 1 in the reset cycle; mask it so no transfer is seen.
    assign out_valid   = s2_valid && !reset;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x, input logic [SW-1:0] n);
        logic [6:0] n7;
        n7 = {2'b00, n};
        return (x << n7) | (x >> (7'd64 - n7));
    endfunction

    function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
        return r;
    endfunction

    // Stage 1 register
    // NOTE: only the valid flag needs reset; payload registers are qualified by it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            // NOTE: sequential state always uses non-blocking assignments.
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_data  <= D_in;
            s1_samt  <= samt;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Shift datapath between stages, built from a single left-rotate primitive plus masks
    logic [DW-1:0] rol_res, ror_res, sll_res, srl_res, sra_res;
    logic [DW-1:0] ones, sll_mask, srl_mask;
    logic [DW-1:0] nxt_data;
    logic          nxt_err;
    logic          nxt_carry;
    logic [5:0]    sll_idx, srl_idx;

    assign ones     = '1;
    assign sll_mask = ones << s1_samt;
    assign srl_mask = ones >> s1_samt;
    assign rol_res  = rotl(s1_data, s1_samt);
    assign ror_res  = bit_rev(rotl(bit_rev(s1_data), s1_samt));
    assign sll_res  = rol_res & sll_mask;
    assign srl_res  = ror_res & srl_mask;
    assign sra_res  = srl_res | (s1_data[DW-1] ? ~srl_mask : '0);
    // 64 - n wraps naturally in 6 bits for n in 1..31.
    assign sll_idx  = 6'd0 - {1'b0, s1_samt};
    assign srl_idx  = {1'b0, s1_samt} - 6'd1;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        nxt_data  = s1_data;
        nxt_err   = 1'b0;
        nxt_carry = 1'b0;
        case (op_e'(s1_op))
            OP_ROL: begin
                nxt_data  = rol_res;
                nxt_carry = (s1_samt != '0) && rol_res[0];
            end
            OP_ROR: begin
                nxt_data  = ror_res;
                nxt_carry = (s1_samt != '0) && ror_res[DW-1];
            end
            OP_SLL: begin
                nxt_data  = sll_res;
                nxt_carry = (s1_samt != '0) && s1_data[sll_idx];
            end
            OP_SRL: begin
                nxt_data  = srl_res;
                nxt_carry = (s1_samt != '0) && s1_data[srl_idx];
            end
            OP_SRA: begin
                nxt_data  = sra_res;
                nxt_carry = (s1_samt != '0) && s1_data[srl_idx];
            end
            default: nxt_err = 1'b1;
        endcase
    end

    // Stage 2 / output register
`ifdef SHIFT_CARRY_EN
    logic carry_q;
    assign carry = carry_q;
`else
    logic unused_carry;
    assign unused_carry = nxt_carry;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            D_out    <= '0;
            zero     <= 1'b0;
            err      <= 1'b0;
`ifdef SHIFT_CARRY_EN
            carry_q  <= 1'b0;
`endif
        end else if (s1_advance) begin
            s2_valid <= 1'b1;
            D_out    <= nxt_data;
            zero     <= (nxt_data == '0);
            err      <= nxt_err;
`ifdef SHIFT_CARRY_EN
            carry_q  <= nxt_carry;
`endif
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: doc/shift_exec_pipe.md
Name: shift_exec_pipe

Overview:
Two-stage pipelined shift/rotate execution unit with valid/ready handshakes on both sides. It accepts a 64-bit operand, a 5-bit shift amount and an opcode. It produces rotate-left, rotate-right, logical-left, logical-right and arithmetic-right results using an internal left-rotate network plus masking. It sits between the operand-issue stage and the writeback stage of the datapath.

Parameters:
DW, 64, operand width; only 64 is supported.
SW, 5, shift-amount width; amounts 0-31.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents an operation
in_ready  output  1  unit accepts the operation this cycle
op  input  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA; 101-111 illegal
D_in  input  DW  operand
samt  input  SW  shift amount
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
D_out  output  DW  result
zero  output  1  D_out == 0
err  output  1  result came from an illegal op
carry  output  1  only when SHIFT_CARRY_EN is defined; see Optional Feature

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. While reset is high, s1_valid, out_valid, D_out, zero, err and carry are all 0 at the next edge, and any in-flight operations are discarded. in_ready is 0 during reset and 1 in the first cycle after reset deasserts.
- Transfers: an input transfer occurs on a clk edge with in_valid && in_ready; an output transfer occurs with out_valid && out_ready.
- Stage 1 (S1): on an input transfer, registers op, D_in and samt, and sets s1_valid.
- Stage 2 (S2/output): loads the S1 result when S1 advances.
- Advance rules:
  - S2 can load when !out_valid || out_ready.
  - S1 advances when s1_valid and S2 can load.
  - in_ready = !s1_valid || (S2 can load). This is combinational and gives full throughput of 1 operation per cycle.
- Latency: a result appears on out_valid/D_out 2 cycles after acceptance if there is no backpressure.
- Stalls: while out_valid && !out_ready, D_out, zero, err and carry hold stable, and S1 holds. in_ready falls once S1 is also full, so at most 2 operations are in flight.
- Simultaneous output transfer and S1 advance in the same cycle: S2 is overwritten with the new result and out_valid stays 1 (no bubble).
- Datapath, with n = samt and R = D_in rotated left by n:
  - ROL: R.
  - ROR: bit-reverse D_in, rotate left by n, then bit-reverse the result.
  - SLL: R AND (all-ones << n).
  - SRL: ROR result AND (all-ones >> n).
  - SRA: SRL result OR (sign-fill in the top n bits when D_in[63] = 1).
- n = 0 for any legal op: D_out = D_in.
- Illegal op: D_out = D_in and err = 1. err = 0 for legal ops.
- zero is computed from the final D_out value and registered with it.
- in_valid while in_ready = 0: the upstream stage must hold the op; the unit samples nothing.
- Reset asserted mid-stall: the pending result is dropped and no transfer occurs on that edge.

Optional Feature:
- Macro SHIFT_CARRY_EN.
- Defined: a carry output port exists, registered in S2 alongside D_out.
  - SLL: D_in[64-n] for n > 0.
  - SRL/SRA: D_in[n-1] for n > 0.
  - ROL: D_out[0]. ROR: D_out[63].
  - n = 0 or illegal op: 0.
- Not defined: no carry port and no carry logic; all other behaviour is identical.

Test Plan:
- Reset held for 3 cycles, then released → out_valid = 0, D_out = 0, in_ready = 1 one cycle after release.
- ROL 0x8000000000000001 by 1, out_ready = 1 → 2 cycles later D_out = 0x0000000000000003, zero = 0.
- ROR 0x0123456789ABCDEF by 4 → D_out = 0xF0123456789ABCDE. With SHIFT_CARRY_EN defined, carry = 1.
- SRA 0x8000000000000000 by 31 → 0xFFFFFFFF00000000; SRL with the same operands → 0x0000000100000000; SLL 0xFFFFFFFFFFFFFFFF by 31 → 0xFFFFFFFF80000000.
- Back-to-back ops with out_ready held 0 for 4 cycles → in_ready = 0 after 2 accepts, D_out stable while stalled; after out_ready = 1, results drain in order with no loss or duplication.
- Illegal op = 110 with D_in = 0 → D_out = 0, err = 1, zero = 1. Reset asserted during this stall → out_valid = 0 next cycle.
